// File: rtl/disp_arb_pkg.sv
// Shared definitions for the display/log message arbiter.
// Holds the default configuration, the source-index width helper and a
// packed message view matching the default configuration.
package disp_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ID_W    = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TS_W    = 32;

   // Width of a requester index; never narrower than one bit.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_SRC_W = src_width(DEF_NUM_REQ);

   typedef struct packed {
      logic [DEF_SRC_W-1:0]  src;
      logic [DEF_ID_W-1:0]   id;
      logic [DEF_DATA_W-1:0] data;
   } disp_msg_t;

endpackage

// File: rtl/disp_arbiter_rr_picker.sv
// Combinational round-robin priority select.
// Scans req starting at rr_ptr, wrapping modulo NUM_REQ, and reports the
// first requester found as a one-hot grant plus its index.
module rr_picker
   import disp_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int SRC_W  = src_width(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SRC_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [SRC_W-1:0]   grant_idx,
   output logic               any
);

   logic [SRC_W:0]   sum;
   logic [SRC_W-1:0] idx;

   // Walk the requesters in rotated order and keep only the first hit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (sum >= (SRC_W+1)'(NUM_REQ)) begin
            sum = sum - (SRC_W+1)'(NUM_REQ);
         end
         idx = sum[SRC_W-1:0];
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing one registered display/log message channel
// among NUM_REQ requesters. Valid/ready on both sides, one message per
// cycle, no bubble when the sink drains and a new grant loads together.
// Optional capture timestamp enabled by defining DISP_ARB_TIMESTAMP_EN.
module disp_arbiter
   import disp_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = DEF_ID_W,
   parameter int DATA_W  = DEF_DATA_W,
`ifdef DISP_ARB_TIMESTAMP_EN
   parameter int TS_W    = DEF_TS_W,
`endif
   localparam int SRC_W  = src_width(NUM_REQ)
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ID_W-1:0]     req_id,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SRC_W-1:0]            out_src,
   output logic [ID_W-1:0]             out_id,
   output logic [DATA_W-1:0]           out_data,
`ifdef DISP_ARB_TIMESTAMP_EN
   output logic [TS_W-1:0]             out_ts,
`endif
   output logic                        busy
);

   logic               can_load;
   logic               accept;
   logic [NUM_REQ-1:0] grant;
   logic [SRC_W-1:0]   grant_idx;
   logic               any;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   next_ptr;
   logic [ID_W-1:0]    id_sel;
   logic [DATA_W-1:0]  data_sel;

   rr_picker #(
      .NUM_REQ   (NUM_REQ)
   ) u_picker (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   // The output register can take a new message when empty or draining.
   assign can_load  = ~out_valid | out_ready;
   assign accept    = can_load & any;
   assign req_ready = (rst_n && can_load) ? grant : '0;
   assign busy      = out_valid & ~out_ready;

   // Select the granted requester's id and payload from the packed buses.
   always_comb begin
      id_sel   = '0;
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            id_sel   = req_id[i*ID_W +: ID_W];
            data_sel = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Pointer moves to the source just after the winner, wrapping to zero.
   always_comb begin
      next_ptr = '0;
      if (grant_idx != SRC_W'(NUM_REQ-1)) begin
         next_ptr = grant_idx + SRC_W'(1);
      end
   end

   // Output register and round-robin pointer; held while the sink stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_src   <= '0;
         out_id    <= '0;
         out_data  <= '0;
         rr_ptr    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_src   <= grant_idx;
         out_id    <= id_sel;
         out_data  <= data_sel;
         rr_ptr    <= next_ptr;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DISP_ARB_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   // Free-running cycle counter used to stamp accepted messages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
      end
   end

   // Timestamp travels with the message it was captured for.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ts <= '0;
      end else if (accept) begin
         out_ts <= ts_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: a vector table for the basic
// round-robin sequence, hand sequences for stall, async reset and
// timestamp, and a random phase against a distance-based reference model.
module tb_disp_arbiter;
   import disp_arb_pkg::*;

   localparam int N  = 4;
   localparam int IW = 8;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*IW-1:0] req_id = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [1:0]      out_src;
   logic [IW-1:0]   out_id;
   logic [DW-1:0]   out_data;
   logic            busy;
`ifdef DISP_ARB_TIMESTAMP_EN
   logic [31:0]     out_ts;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   disp_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_id    (req_id),
      .req_data  (req_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src),
      .out_id    (out_id),
      .out_data  (out_data),
`ifdef DISP_ARB_TIMESTAMP_EN
      .out_ts    (out_ts),
`endif
      .busy      (busy)
   );

   typedef struct {
      logic [N-1:0] reqValid;
      logic         outReady;
      logic [N-1:0] expReady;
      logic         expBusy;
      logic         expValid;
      logic [1:0]   expSrc;
      logic [7:0]   expId;
   } vec_t;

   vec_t vecs[15];

   // Reference model state: the held message and the rotation origin.
   disp_msg_t  mMsg;
   logic       mValid;
   int         mPtr;
   logic [31:0] mCnt;
   logic [31:0] mTs;

   // Winner is the requester at the smallest rotated distance from mPtr.
   function automatic logic [N-1:0] modelGrant(input logic [N-1:0] rv, input logic ordy);
      int best;
      int bestDist;
      logic [N-1:0] g;
      g = '0;
      best = -1;
      bestDist = N;
      if (!(mValid && !ordy)) begin
         for (int i = 0; i < N; i++) begin
            if (rv[i] && ((i - mPtr + N) % N) < bestDist) begin
               bestDist = (i - mPtr + N) % N;
               best = i;
            end
         end
         if (best >= 0) g[best] = 1'b1;
      end
      return g;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] rv, input logic ordy);
      @(negedge clk);
      req_valid = rv;
      out_ready = ordy;
      #1;
   endtask

   task automatic setDefaultIds();
      for (int i = 0; i < N; i++) begin
         req_id[i*IW +: IW]   = 8'(16 + i);
         req_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      end
   endtask

   task automatic modelEdge(input logic [N-1:0] g, input logic ordy);
      if (g != '0) begin
         for (int i = 0; i < N; i++) begin
            if (g[i]) begin
               mMsg.src  = 2'(i);
               mMsg.id   = req_id[i*IW +: IW];
               mMsg.data = req_data[i*DW +: DW];
               mTs       = mCnt;
               mPtr      = (i + 1) % N;
            end
         end
         mValid = 1'b1;
      end else if (ordy) begin
         mValid = 1'b0;
      end
      mCnt = mCnt + 32'd1;
   endtask

   task automatic modelStep(input logic [N-1:0] rv, input logic ordy, output logic [N-1:0] g);
      applyStimulus(rv, ordy);
      g = modelGrant(rv, ordy);
      checkOutput("model req_ready", 64'(req_ready), 64'(g));
      checkOutput("model busy", 64'(busy), 64'(mValid && !ordy));
      @(posedge clk);
      modelEdge(g, ordy);
      #1;
      checkOutput("model out_valid", 64'(out_valid), 64'(mValid));
      if (mValid) begin
         checkOutput("model out_src", 64'(out_src), 64'(mMsg.src));
         checkOutput("model out_id", 64'(out_id), 64'(mMsg.id));
         checkOutput("model out_data", 64'(out_data), 64'(mMsg.data));
`ifdef DISP_ARB_TIMESTAMP_EN
         checkOutput("model out_ts", 64'(out_ts), 64'(mTs));
`endif
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '1;
      out_ready = 1'b1;
      #1;
      checkOutput("reset req_ready", 64'(req_ready), 64'(0));
      checkOutput("reset out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset busy", 64'(busy), 64'(0));
      checkOutput("reset out_src", 64'(out_src), 64'(0));
      checkOutput("reset out_id", 64'(out_id), 64'(0));
      checkOutput("reset out_data", 64'(out_data), 64'(0));
      @(posedge clk);
      #1;
      checkOutput("reset held req_ready", 64'(req_ready), 64'(0));
      checkOutput("reset held out_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      @(posedge clk);
      #1;
      mValid = 1'b0;
      mPtr = 0;
      mCnt = 32'd1;
      mTs = 32'd0;
      mMsg = '0;
   endtask

   initial begin
      logic [N-1:0] g;
      logic [N-1:0] pend;
      logic [N-1:0] rv;
      logic         ordy;

      vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'h10};
      vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 8'h11};
      vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h12};
      vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 8'h13};
      vecs[4]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h12};
      vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h12};
      vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h12};
      vecs[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 8'h13};
      vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'h10};
      vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
      vecs[10] = '{4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 8'h11};
      vecs[11] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h11};
      vecs[12] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h11};
      vecs[13] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h11};
      vecs[14] = '{4'b0011, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'h10};

      // Table: rotation, single source, wrap, empty drain, stall.
      doReset();
      setDefaultIds();
      for (int v = 0; v < 15; v++) begin
         applyStimulus(vecs[v].reqValid, vecs[v].outReady);
         checkOutput($sformatf("vec%0d req_ready", v), 64'(req_ready), 64'(vecs[v].expReady));
         checkOutput($sformatf("vec%0d busy", v), 64'(busy), 64'(vecs[v].expBusy));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'(vecs[v].expValid));
         if (vecs[v].expValid) begin
            checkOutput($sformatf("vec%0d out_src", v), 64'(out_src), 64'(vecs[v].expSrc));
            checkOutput($sformatf("vec%0d out_id", v), 64'(out_id), 64'(vecs[v].expId));
            checkOutput($sformatf("vec%0d out_data", v), 64'(out_data),
                        64'(32'hD000_0000 + 32'(vecs[v].expSrc)));
         end
      end

      // Backpressure: a held A5 message must not move for five cycles.
      doReset();
      setDefaultIds();
      req_id[7:0] = 8'hA5;
      applyStimulus(4'b0001, 1'b0);
      checkOutput("bp first req_ready", 64'(req_ready), 64'(4'b0001));
      @(posedge clk);
      #1;
      checkOutput("bp loaded id", 64'(out_id), 64'(8'hA5));
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0011, 1'b0);
         checkOutput("bp stall req_ready", 64'(req_ready), 64'(0));
         checkOutput("bp stall busy", 64'(busy), 64'(1));
         @(posedge clk);
         #1;
         checkOutput("bp stall out_valid", 64'(out_valid), 64'(1));
         checkOutput("bp stall out_id", 64'(out_id), 64'(8'hA5));
         checkOutput("bp stall out_src", 64'(out_src), 64'(0));
         checkOutput("bp stall out_data", 64'(out_data), 64'(32'hD000_0000));
      end
      applyStimulus(4'b0011, 1'b1);
      checkOutput("bp release req_ready", 64'(req_ready), 64'(4'b0010));
      @(posedge clk);
      #1;
      checkOutput("bp release out_src", 64'(out_src), 64'(1));
      checkOutput("bp release out_id", 64'(out_id), 64'(8'h11));

      // Async reset while FULL and stalled clears without a clock edge.
      applyStimulus(4'b0011, 1'b0);
      checkOutput("ar full before", 64'(out_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar out_valid", 64'(out_valid), 64'(0));
      checkOutput("ar req_ready", 64'(req_ready), 64'(0));
      checkOutput("ar busy", 64'(busy), 64'(0));

      // Timestamp: accept three cycles after release carries a stamp of 3.
      doReset();
      modelStep(4'b0000, 1'b1, g);
      modelStep(4'b0000, 1'b1, g);
      modelStep(4'b0001, 1'b1, g);
`ifdef DISP_ARB_TIMESTAMP_EN
      checkOutput("ts after release", 64'(out_ts), 64'(3));
`endif

      // Random traffic honouring the hold-until-ready requester contract.
      doReset();
      pend = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               req_id[i*IW +: IW]   = 8'($urandom);
               req_data[i*DW +: DW] = $urandom;
            end
         end
         rv = pend;
         ordy = ($urandom_range(0, 3) != 0);
         modelStep(rv, ordy, g);
         pend = pend & ~g;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares one registered display/log message channel among NUM_REQ conditional-display requesters. Each requester is typically an always block gated by a posedge-clk condition.
- Round-robin arbitration, one message accepted per cycle, valid/ready on both sides.
- Sits between per-unit trace/check logic and a single message sink (log formatter or trace port).

Parameters:
- NUM_REQ, 4, number of requesters, 2..16
- ID_W, 8, message identifier width
- DATA_W, 32, message payload width
- TS_W, 32, timestamp width (used only with DISP_ARB_TIMESTAMP_EN)

Ports:
- clk  input  1  system clock, posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester message valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_id  input  NUM_REQ*ID_W  packed ids, requester i at [i*ID_W +: ID_W]
- req_data  input  NUM_REQ*DATA_W  packed payloads, same packing
- out_valid  output  1  message valid to sink
- out_ready  input  1  sink accept
- out_src  output  SRC_W=$clog2(NUM_REQ)  index of the granted requester
- out_id  output  ID_W  granted id
- out_data  output  DATA_W  granted payload
- out_ts  output  TS_W  capture timestamp (present only with macro)
- busy  output  1  out_valid & ~out_ready (sink stalled)

Behaviour:
- Reset values: out_valid=0, out_src=0, out_id=0, out_data=0, out_ts=0, rr_ptr=0, req_ready=0, busy=0.
- Reset is async assert; all state clears immediately. Reset mid-message drops the held message with no replay.
- Requester contract: once req_valid is high, it stays high with stable id/data until req_ready. The arbiter does not check this.
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- can_load = ~out_valid | out_ready.
- Grant is combinational. When can_load, grant goes to the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. req_ready[grant]=1, all other req_ready=0.
- When can_load=0, all req_ready=0.
- Handshake on req_valid[i]&req_ready[i]: next edge loads out_src=i, out_id, out_data, sets out_valid=1, and sets rr_ptr=(i+1) mod NUM_REQ. At i=NUM_REQ-1, rr_ptr wraps to 0.
- Latency: request accepted in cycle N appears at the output in cycle N+1.
- Throughput: 1 message/cycle when out_ready is held high.
- Sink accepts and new grant in the same cycle: the register reloads with the new message and out_valid stays 1 (no bubble).
- Sink accepts with no request pending: out_valid goes to 0 next edge.
- FULL and out_ready=0: all output fields stay stable, rr_ptr is unchanged, busy=1.
- No requests pending: rr_ptr is unchanged.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 grants.

Optional Feature:
- Macro: DISP_ARB_TIMESTAMP_EN.
- Defined:
  - Free-running TS_W-bit cycle counter, reset to 0, increments every clk, wraps 2^TS_W-1 → 0.
  - out_ts captures the counter value of the accept cycle and loads alongside out_id/out_data.
- Undefined: out_ts port and counter are absent. All other behaviour is identical.

Decomposition:
- Package disp_arb_pkg:
  - localparam defaults NUM_REQ, ID_W, DATA_W, TS_W
  - function for SRC_W
  - typedef struct packed disp_msg_t {src, id, data}
- Sub-module rr_picker: combinational round-robin priority select.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant one-hot, grant index, any.
- disp_arbiter owns the output register, rr_ptr and the timestamp counter.

Test Plan:
- Reset: hold rst_n=0, then drive req_valid=4'b1111 → req_ready=0 and out_valid=0 throughout reset; out_id=0, out_data=0.
- Release rst_n, req_valid=4'b1111 (id i = 8'h10+i), out_ready=1 for 4 cycles → out_src 0,1,2,3 on consecutive cycles, out_id 8'h10..8'h13, no bubbles.
- Single source: req_valid=4'b0100 for 3 cycles, out_ready=1 → out_src=2 each cycle; rr_ptr=3 after each grant.
- Backpressure: output FULL with out_id=8'hA5, out_ready=0 for 5 cycles while req_valid=4'b0011 → out fields stable, req_ready=0, busy=1. Raise out_ready → next message is from the round-robin next source.
- Wrap: rr_ptr=3, req_valid=4'b1001 → grant 3, then grant 0; rr_ptr 3→0→1.
- Async reset while FULL (out_valid=1, out_ready=0) → out_valid drops to 0 without a clk edge. With DISP_ARB_TIMESTAMP_EN, the first accept 3 cycles after release shows out_ts=3 on the next cycle.
